sernor_shifter: RTL and testbench



---
 rtl/sernor_shifter.sv | 179 +++++++++++++++++
 tb/tb_sernor_shifter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sernor_shifter.sv
// Serial NOR flash burst shifter: 1/2/4/8 lanes, up to MAX_BYTES bytes per trigger.
// Optional build macro SERNOR_LATE_SAMPLE_EN moves spi_din sampling to the falling SCLK edge.
module sernor_shifter #(
  parameter int unsigned MAX_BYTES = 4,
  parameter int unsigned CLK_DIV   = 1,
  parameter bit          CPOL      = 1'b1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_trig,
  output logic                   o_busy,
  output logic                   o_done,
  input  logic                   i_dir,
  input  logic [1:0]             i_wid,
  input  logic [3:0]             i_nbytes,
  input  logic [8*MAX_BYTES-1:0] i_tx_data,
  output logic [8*MAX_BYTES-1:0] o_rx_data,
  output logic                   o_spi_sclk,
  output logic                   o_spi_oe,
  output logic [7:0]             o_spi_dout,
  input  logic [7:0]             i_spi_din
);

  localparam int unsigned NBITS = 8 * MAX_BYTES;

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StFin} state_e;

  state_e           r_state;
  logic [7:0]       r_div;
  logic [6:0]       r_pulses;
  logic             r_dir;
  logic [1:0]       r_wid;
  logic [3:0]       r_nb;
  logic [NBITS-1:0] r_tx;
  logic [NBITS-1:0] r_rxsh;
  logic [NBITS-1:0] r_rx_data;
  logic             r_busy;
  logic             r_done;
  logic             r_sclk;
  logic             r_oe;
  logic [7:0]       r_dout;

  logic [3:0]       w_nb;
  logic [6:0]       w_pulses;
  logic [3:0]       w_lanes_in;
  logic [3:0]       w_lanes;
  logic [NBITS-1:0] w_stream;
  logic [7:0]       w_stream_top;
  logic [7:0]       w_tx_top;
  logic [7:0]       w_rx_mask;
  logic [NBITS-1:0] w_rx_shift;
  logic [NBITS-1:0] w_rx_final;
  logic [NBITS-1:0] w_rx_map;
  logic             w_div_end;

  // The transmit stream keeps byte0 at the top so every pulse simply takes the top lanes bits.
  always_comb begin
    w_nb         = (i_nbytes > 4'(MAX_BYTES)) ? 4'(MAX_BYTES) : i_nbytes;
    w_pulses     = ({3'b000, w_nb} << 3) >> i_wid;
    w_lanes_in   = 4'd1 << i_wid;
    w_lanes      = 4'd1 << r_wid;
    w_stream     = '0;
    for (int i = 0; i < int'(MAX_BYTES); i++) begin
      w_stream[NBITS-1-8*i -: 8] = i_tx_data[8*i +: 8];
    end
    w_stream_top = w_stream[NBITS-1 -: 8] >> (4'd8 - w_lanes_in);
    w_tx_top     = r_tx[NBITS-1 -: 8] >> (4'd8 - w_lanes);
    w_rx_mask    = 8'((9'd1 << w_lanes) - 9'd1);
    w_rx_shift   = r_rxsh << w_lanes;
    w_rx_shift[7:0] = w_rx_shift[7:0] | (i_spi_din & w_rx_mask);
    w_div_end    = (r_div == 8'(CLK_DIV - 1));
`ifdef SERNOR_LATE_SAMPLE_EN
    // Last sample lands on the same edge that enters FIN.
    w_rx_final   = w_rx_shift;
`else
    w_rx_final   = r_rxsh;
`endif
    // First received byte sits highest among the nb collected bytes.
    w_rx_map     = '0;
    for (int i = 0; i < int'(MAX_BYTES); i++) begin
      if (i < int'(r_nb)) begin
        w_rx_map[8*i +: 8] = w_rx_final[8*(int'(r_nb)-1-i) +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_div     <= '0;
      r_pulses  <= '0;
      r_dir     <= 1'b0;
      r_wid     <= '0;
      r_nb      <= '0;
      r_tx      <= '0;
      r_rxsh    <= '0;
      r_rx_data <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sclk    <= CPOL;
      r_oe      <= 1'b0;
      r_dout    <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_trig) begin
            r_dir  <= i_dir;
            r_wid  <= i_wid;
            r_nb   <= w_nb;
            r_busy <= 1'b1;
            r_oe   <= i_dir;
            r_div  <= '0;
            r_rxsh <= '0;
            if (w_nb == 4'd0) begin
              r_state <= StFin;
              r_done  <= 1'b1;
            end else begin
              r_state  <= StLow;
              r_sclk   <= 1'b0;
              r_pulses <= w_pulses;
              r_dout   <= w_stream_top;
              r_tx     <= w_stream << w_lanes_in;
            end
          end
        end
        StLow: begin
`ifndef SERNOR_LATE_SAMPLE_EN
          if (w_div_end) r_rxsh <= w_rx_shift;
`endif
          if (w_div_end) begin
            r_div    <= '0;
            r_state  <= StHigh;
            r_sclk   <= 1'b1;
            r_pulses <= r_pulses - 7'd1;
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        StHigh: begin
`ifdef SERNOR_LATE_SAMPLE_EN
          if (w_div_end) r_rxsh <= w_rx_shift;
`endif
          if (w_div_end) begin
            r_div <= '0;
            if (r_pulses != 7'd0) begin
              r_state <= StLow;
              r_sclk  <= 1'b0;
              r_dout  <= w_tx_top;
              r_tx    <= r_tx << w_lanes;
            end else begin
              r_state <= StFin;
              r_sclk  <= CPOL;
              r_done  <= 1'b1;
              r_dout  <= '0;
              if (!r_dir) r_rx_data <= w_rx_map;
            end
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        StFin: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_oe    <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_rx_data  = r_rx_data;
  assign o_spi_sclk = r_sclk;
  assign o_spi_oe   = r_oe;
  assign o_spi_dout = r_dout;

endmodule

// File: tb/tb_sernor_shifter.sv
// Bench for sernor_shifter: vector table on a CLK_DIV=1/CPOL=1 instance, divider test on a
// CLK_DIV=3/CPOL=0 instance, plus reset-mid-burst and sample-edge sequences.
module tb_sernor_shifter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance a: CLK_DIV=1, CPOL=1
  logic        a_trig = 0, a_dir = 0;
  logic [1:0]  a_wid = 0;
  logic [3:0]  a_nb = 0;
  logic [31:0] a_tx = 0, a_rx;
  logic [7:0]  a_din = 0, a_dout;
  logic        a_busy, a_done, a_sclk, a_oe;

  // Instance b: CLK_DIV=3, CPOL=0
  logic        b_trig = 0, b_dir = 0;
  logic [1:0]  b_wid = 0;
  logic [3:0]  b_nb = 0;
  logic [31:0] b_tx = 0, b_rx;
  logic [7:0]  b_din = 0, b_dout;
  logic        b_busy, b_done, b_sclk, b_oe;

  sernor_shifter #(.MAX_BYTES(4), .CLK_DIV(1), .CPOL(1'b1)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_trig(a_trig), .o_busy(a_busy), .o_done(a_done),
    .i_dir(a_dir), .i_wid(a_wid), .i_nbytes(a_nb), .i_tx_data(a_tx), .o_rx_data(a_rx),
    .o_spi_sclk(a_sclk), .o_spi_oe(a_oe), .o_spi_dout(a_dout), .i_spi_din(a_din)
  );

  sernor_shifter #(.MAX_BYTES(4), .CLK_DIV(3), .CPOL(1'b0)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_trig(b_trig), .o_busy(b_busy), .o_done(b_done),
    .i_dir(b_dir), .i_wid(b_wid), .i_nbytes(b_nb), .i_tx_data(b_tx), .o_rx_data(b_rx),
    .o_spi_sclk(b_sclk), .o_spi_oe(b_oe), .o_spi_dout(b_dout), .i_spi_din(b_din)
  );

  typedef struct {
    logic        dir;
    logic [1:0]  wid;
    logic [3:0]  nb;
    logic [31:0] tx;
    logic [31:0] rdata;
    bit          busy_trig;
    bit          done_trig;
    int          exp_lat;
    logic [31:0] exp_rx;
  } vec_t;

  typedef struct {
    int          lat;
    int          pulses;
    logic [31:0] rx;
  } res_t;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_dout_q[$];
  res_t       exp_res_q[$];
  logic [7:0] din_q[$];
  bit         nor_rise = 0;

  // NOR model for instance a: presents the next lane value on the chosen SCLK edge.
  always @(a_sclk) begin
    if (a_sclk == nor_rise && din_q.size() > 0) a_din = din_q.pop_front();
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  task automatic run_burst(input vec_t v, input bit own_model);
    int         nbe, lanes, cyc, rises;
    logic       prev;
    bit         oe_bad, seen;
    logic [7:0] mask, b, chunk;
    res_t       e, r;
    nbe   = (v.nb > 4) ? 4 : int'(v.nb);
    lanes = 1 << v.wid;
    mask  = 8'((1 << lanes) - 1);
    @(negedge clk);
    a_dir = v.dir; a_wid = v.wid; a_nb = v.nb; a_tx = v.tx; a_trig = 1'b1;
    if (!own_model) begin
      din_q.delete();
      nor_rise = 0;
    end
    for (int i = 0; i < nbe; i++) begin
      for (int k = 0; k < 8 / lanes; k++) begin
        b = v.tx[8*i +: 8];
        chunk = (b >> (8 - lanes * (k + 1))) & mask;
        if (v.dir) exp_dout_q.push_back(chunk);
        b = v.rdata[8*i +: 8];
        chunk = (b >> (8 - lanes * (k + 1))) & mask;
        if (!v.dir && !own_model) din_q.push_back(chunk);
      end
    end
    e.lat = v.exp_lat; e.pulses = nbe * 8 / lanes; e.rx = v.exp_rx;
    exp_res_q.push_back(e);
    prev = a_sclk;
    @(negedge clk);
    a_trig = 1'b0;
    // Scramble inputs: the burst must run on the latched copies.
    a_dir = ~v.dir; a_wid = ~v.wid; a_nb = 4'd15; a_tx = ~v.tx;
    cyc = 1; rises = 0; oe_bad = 0; seen = 0;
    while (cyc <= 200) begin
      if (prev && !a_sclk && exp_dout_q.size() > 0) check("dout", a_dout, exp_dout_q.pop_front());
      if (!prev && a_sclk) rises++;
      if (a_busy && a_oe !== v.dir) oe_bad = 1;
      if (v.busy_trig) a_trig = (cyc == 2);
      prev = a_sclk;
      if (a_done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL timeout: no done within %0d cycles, expected %0d", cyc, v.exp_lat);
      exp_res_q.delete();
    end else begin
      r = exp_res_q.pop_front();
      check("latency", cyc, r.lat);
      check("pulses", rises, r.pulses);
      check("rx_data", a_rx, r.rx);
      check("oe_bad", {31'b0, oe_bad}, 0);
      check("dout_left", exp_dout_q.size(), 0);
    end
    exp_dout_q.delete();
    if (v.done_trig) a_trig = 1'b1;
    @(negedge clk);
    a_trig = 1'b0;
    check("done_pulse", a_done, 0);
    check("busy_after", a_busy, 0);
    @(negedge clk);
    check("busy_after2", a_busy, 0);
  endtask

  vec_t vecs[8];
  vec_t v;

  initial begin
    int cyc, hi, lo;
    logic prevb;
    bit oe_bad, seen;

    //        dir wid nb  tx            rdata         bsy dn  lat rx
    vecs[0] = '{1, 0, 1, 32'h000000A5, 32'h0,        0, 0, 17, 32'h00000000};
    vecs[1] = '{0, 2, 2, 32'h0,        32'hFFFF5A3C, 0, 0,  9, 32'h00005A3C};
    vecs[2] = '{0, 0, 0, 32'h0,        32'h12345678, 0, 0,  1, 32'h00005A3C};
    vecs[3] = '{0, 0, 7, 32'h0,        32'hDEADBEEF, 1, 0, 65, 32'hDEADBEEF};
    vecs[4] = '{0, 3, 3, 32'h0,        32'hFFC3A596, 0, 1,  7, 32'h00C3A596};
    vecs[5] = '{1, 1, 4, 32'h8BADF00D, 32'h0,        1, 0, 33, 32'h00C3A596};
    vecs[6] = '{0, 1, 1, 32'h0,        32'h0000006E, 0, 1,  9, 32'h0000006E};
    vecs[7] = '{1, 3, 2, 32'h0000C0DE, 32'h0,        0, 0,  5, 32'h0000006E};

    repeat (3) @(negedge clk);
    check("rst_busy", a_busy, 0);
    check("rst_sclk_a", a_sclk, 1);
    check("rst_sclk_b", b_sclk, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_done", a_done, 0);
    check("idle_oe", a_oe, 0);
    check("idle_dout", a_dout, 0);
    check("idle_rx", a_rx, 0);

    for (int i = 0; i < 8; i++) run_burst(vecs[i], 1'b0);

    // Octal write with divider on instance b: 3-cycle half periods.
    @(negedge clk);
    b_dir = 1; b_wid = 3; b_nb = 4; b_tx = 32'h11223344; b_trig = 1;
    exp_dout_q.push_back(8'h44); exp_dout_q.push_back(8'h33);
    exp_dout_q.push_back(8'h22); exp_dout_q.push_back(8'h11);
    prevb = b_sclk;
    @(negedge clk);
    b_trig = 0; b_tx = 0;
    cyc = 1; hi = 0; lo = 0; oe_bad = 0; seen = 0;
    while (cyc <= 100) begin
      if ((cyc == 1 || (prevb && !b_sclk)) && exp_dout_q.size() > 0)
        check("b_dout", b_dout, exp_dout_q.pop_front());
      if (b_busy && !b_done) begin
        if (b_sclk) hi++;
        else lo++;
        if (!b_oe) oe_bad = 1;
      end
      prevb = b_sclk;
      if (b_done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    check("b_done_seen", {31'b0, seen}, 1);
    check("b_latency", cyc, 25);
    check("b_high_cycles", hi, 12);
    check("b_low_cycles", lo, 12);
    check("b_oe_bad", {31'b0, oe_bad}, 0);
    check("b_fin_sclk", b_sclk, 0);
    check("b_dout_left", exp_dout_q.size(), 0);
    exp_dout_q.delete();

    // Reset during the 3rd pulse of a read.
    din_q.delete();
    @(negedge clk);
    a_dir = 0; a_wid = 0; a_nb = 2; a_trig = 1;
    @(negedge clk);
    a_trig = 0;
    repeat (4) @(negedge clk);
    check("pre_rst_sclk", a_sclk, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_sclk", a_sclk, 1);
    check("mid_rst_oe", a_oe, 0);
    check("mid_rst_busy", a_busy, 0);
    check("mid_rst_rx", a_rx, 0);
    check("mid_rst_dout", a_dout, 0);
    @(negedge clk);
    rst = 1'b0;
    v = '{0, 2, 4, 32'h0, 32'h12345678, 0, 0, 17, 32'h12345678};
    run_burst(v, 1'b0);

    // NOR changes data on rising SCLK: the sample edge decides which value lands.
    din_q.delete();
    a_din = 8'h03;
    nor_rise = 1;
    din_q.push_back(8'h09);
    din_q.push_back(8'h06);
`ifdef SERNOR_LATE_SAMPLE_EN
    v = '{0, 2, 1, 32'h0, 32'h0, 0, 0, 5, 32'h00000096};
`else
    v = '{0, 2, 1, 32'h0, 32'h0, 0, 0, 5, 32'h00000039};
`endif
    run_burst(v, 1'b1);
    nor_rise = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
